// File: rtl/rf_param.sv
// Parametrised 2-read/1-write register file with optional hard-wired-zero R0 and a clear sequencer.
// Define RF_BYPASS_EN to forward an accepted same-cycle write onto the read ports.
module rf_param #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 8,
  parameter int SEL_W   = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] readReg1Sel,
  input  logic [SEL_W-1:0] readReg2Sel,
  input  logic [SEL_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0] writeData,
  input  logic             writeEn,
  input  logic             clrReq,
  output logic [WIDTH-1:0] readData1,
  output logic [WIDTH-1:0] readData2,
  output logic             busy,
  output logic             err
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [SEL_W:0]   DEPTH_EXT = (SEL_W+1)'(DEPTH);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(DEPTH - 1);

  state_t           state;
  logic [SEL_W-1:0] clrCnt;
  logic [WIDTH-1:0] regs [DEPTH];

  logic writeInRange;
  logic writeToZero;
  logic writeAcc;

  assign writeInRange = {1'b0, writeRegSel} < DEPTH_EXT;
  assign writeToZero  = (ZERO_R0 != 0) && (writeRegSel == '0);
  assign writeAcc     = (state == IDLE) && writeEn && writeInRange && !writeToZero;

  function automatic logic [WIDTH-1:0] readPort(input logic [SEL_W-1:0] sel);
    logic [WIDTH-1:0] val;
    val = '0;
    if (({1'b0, sel} < DEPTH_EXT) && !((ZERO_R0 != 0) && (sel == '0))) begin
      val = regs[sel];
`ifdef RF_BYPASS_EN
      if (writeAcc && (writeRegSel == sel)) val = writeData;
`endif
    end
    return val;
  endfunction

  always_comb begin
    readData1 = readPort(readReg1Sel);
    readData2 = readPort(readReg2Sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      clrCnt <= '0;
      busy   <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      // Dropped writes: anything during the clear sweep, or an out-of-range select.
      err <= writeEn && ((state == CLEAR) || !writeInRange);
      case (state)
        IDLE: begin
          if (writeAcc) regs[writeRegSel] <= writeData;
          if (clrReq) begin
            state  <= CLEAR;
            busy   <= 1'b1;
            clrCnt <= '0;
          end
        end
        CLEAR: begin
          regs[clrCnt] <= '0;
          if (clrCnt == LAST_IDX) begin
            state  <= IDLE;
            busy   <= 1'b0;
            clrCnt <= '0;
          end else begin
            clrCnt <= clrCnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
